inventory_txn_arbiter: RTL

Round-robin arbiter and sequencer that shares the single shelf-update datapath between two requesters: requester 0 is the restock terminal and requester 1 is the checkout terminal. It accepts one transaction at a time through a valid/ready handshake and gates it with the session `enabled` flag from the password unit. It then issues the add or sub to the datapath, waits for completion with a timeout, and returns a per-requester status pulse.

---
 rtl/inventory_txn_arbiter_if.sv | 58 +++++
 rtl/inventory_txn_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/inventory_txn_arbiter_if.sv
// Requester, response and datapath signals of the inventory transaction arbiter.
interface inventory_txn_arbiter_if;
    logic       enabled;

    logic       req0_valid;
    logic       req0_ready;
    logic [5:0] req0_id;
    logic [3:0] req0_qty;
    logic       req0_sub;

    logic       req1_valid;
    logic       req1_ready;
    logic [5:0] req1_id;
    logic [3:0] req1_qty;
    logic       req1_sub;

    logic       rsp0_valid;
    logic [1:0] rsp0_status;
    logic       rsp1_valid;
    logic [1:0] rsp1_status;

    logic       dp_valid;
    logic [5:0] dp_id;
    logic [3:0] dp_add;
    logic [3:0] dp_sub;
    logic       dp_done;
    logic       dp_ovf;
    logic       dp_unf;

    logic       busy;
    logic [7:0] txn_count;

    // Arbiter side
    modport slave (
        input  enabled,
        input  req0_valid, req0_id, req0_qty, req0_sub,
        output req0_ready,
        input  req1_valid, req1_id, req1_qty, req1_sub,
        output req1_ready,
        output rsp0_valid, rsp0_status, rsp1_valid, rsp1_status,
        output dp_valid, dp_id, dp_add, dp_sub,
        input  dp_done, dp_ovf, dp_unf,
        output busy, txn_count
    );

    // Requester / datapath / environment side
    modport master (
        output enabled,
        output req0_valid, req0_id, req0_qty, req0_sub,
        input  req0_ready,
        output req1_valid, req1_id, req1_qty, req1_sub,
        input  req1_ready,
        input  rsp0_valid, rsp0_status, rsp1_valid, rsp1_status,
        input  dp_valid, dp_id, dp_add, dp_sub,
        output dp_done, dp_ovf, dp_unf,
        input  busy, txn_count
    );
endinterface

// File: rtl/inventory_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing the shelf-update datapath between
// the restock (0) and checkout (1) terminals.
module inventory_txn_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    inventory_txn_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_OVF  = 2'b01;
    localparam logic [1:0] ST_UNF  = 2'b10;
    localparam logic [1:0] ST_REJ  = 2'b11;

    state_t     state_q, state_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       owner_q, owner_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] txn_count_q, txn_count_d;
    logic       dp_valid_q, dp_valid_d;
    logic [5:0] dp_id_q, dp_id_d;
    logic [3:0] dp_add_q, dp_add_d;
    logic [3:0] dp_sub_q, dp_sub_d;
    logic       rsp0_valid_q, rsp0_valid_d;
    logic       rsp1_valid_q, rsp1_valid_d;
    logic [1:0] rsp0_status_q, rsp0_status_d;
    logic [1:0] rsp1_status_q, rsp1_status_d;

    logic       grant1;
    logic       hs;
    logic [5:0] sel_id;
    logic [3:0] sel_qty;
    logic       sel_sub;

    // Combinational grant: a lone requester wins, otherwise rr_ptr decides
    always_comb begin
        grant1  = bus.req1_valid & (~bus.req0_valid | rr_ptr_q);
        hs      = (state_q == S_IDLE) & (bus.req0_valid | bus.req1_valid);
        sel_id  = grant1 ? bus.req1_id  : bus.req0_id;
        sel_qty = grant1 ? bus.req1_qty : bus.req0_qty;
        sel_sub = grant1 ? bus.req1_sub : bus.req0_sub;
    end

    assign bus.req0_ready = hs & ~grant1;
    assign bus.req1_ready = hs & grant1;

    // Next-state and registered-output computation
    always_comb begin
        logic       go_resp;
        logic [1:0] resp_status;

        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        txn_count_d   = txn_count_q;
        dp_valid_d    = 1'b0;
        dp_id_d       = dp_id_q;
        dp_add_d      = dp_add_q;
        dp_sub_d      = dp_sub_q;
        rsp0_valid_d  = 1'b0;
        rsp1_valid_d  = 1'b0;
        rsp0_status_d = '0;
        rsp1_status_d = '0;
        go_resp       = 1'b0;
        resp_status   = ST_OK;

        unique case (state_q)
            S_IDLE: begin
                dp_id_d  = '0;
                dp_add_d = '0;
                dp_sub_d = '0;
                if (hs) begin
                    owner_d = grant1;
                    if (!bus.enabled) begin
                        go_resp     = 1'b1;
                        resp_status = ST_REJ;
                    end else if (sel_qty == '0) begin
                        go_resp     = 1'b1;
                        resp_status = ST_OK;
                    end else begin
                        state_d    = S_ISSUE;
                        dp_valid_d = 1'b1;
                        dp_id_d    = sel_id;
                        dp_add_d   = sel_sub ? '0 : sel_qty;
                        dp_sub_d   = sel_sub ? sel_qty : '0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (bus.dp_done) begin
                    go_resp     = 1'b1;
                    resp_status = bus.dp_ovf ? ST_OVF : (bus.dp_unf ? ST_UNF : ST_OK);
                    txn_count_d = txn_count_q + 8'd1;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    go_resp     = 1'b1;
                    resp_status = ST_REJ;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d  = S_IDLE;
                rr_ptr_d = ~owner_q;
                dp_id_d  = '0;
                dp_add_d = '0;
                dp_sub_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Response is registered, so it is launched on the transition into RESP
        if (go_resp) begin
            state_d = S_RESP;
            if (owner_d) begin
                rsp1_valid_d  = 1'b1;
                rsp1_status_d = resp_status;
            end else begin
                rsp0_valid_d  = 1'b1;
                rsp0_status_d = resp_status;
            end
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= 1'b0;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            txn_count_q   <= '0;
            dp_valid_q    <= 1'b0;
            dp_id_q       <= '0;
            dp_add_q      <= '0;
            dp_sub_q      <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_status_q <= '0;
            rsp1_status_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            txn_count_q   <= txn_count_d;
            dp_valid_q    <= dp_valid_d;
            dp_id_q       <= dp_id_d;
            dp_add_q      <= dp_add_d;
            dp_sub_q      <= dp_sub_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_status_q <= rsp0_status_d;
            rsp1_status_q <= rsp1_status_d;
        end
    end

    assign bus.dp_valid    = dp_valid_q;
    assign bus.dp_id       = dp_id_q;
    assign bus.dp_add      = dp_add_q;
    assign bus.dp_sub      = dp_sub_q;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp0_status = rsp0_status_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp1_status = rsp1_status_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.txn_count   = txn_count_q;

endmodule
